// File: rtl/cpkt_seg.sv
// Cuts one wide composite packet into CELL_SZ back-to-back cells tagged with SOC/EOC.
// Optional one-packet holding buffer is enabled with `define CPKT_SEG_BUF_EN.
module cpkt_seg #(
  parameter int DWID    = 256,
  parameter int FCMWID  = 50,
  parameter int EOC_MSB = 2,
  parameter int EOC_LSB = 2,
  parameter int SOC_MSB = 3,
  parameter int SOC_LSB = 3,
  parameter int CELL_SZ = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpkt_vld,
  input  logic [DWID*CELL_SZ-1:0] cpkt_dat,
  input  logic [FCMWID-1:0]       cpkt_msg,
  output logic                    cpkt_rdy,
  output logic                    cell_vld,
  output logic [DWID-1:0]         cell_dat,
  output logic [FCMWID-1:0]       cell_msg
);
  localparam int CNT_W = (CELL_SZ > 1) ? $clog2(CELL_SZ) : 1;
  localparam int PW    = DWID * CELL_SZ;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CELL_SZ - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  idx, idx_nxt;
  logic [PW-1:0]     sh_q;
  logic [FCMWID-1:0] msg_q;
  logic              last, accept, load;
  logic [PW-1:0]     ld_dat;
  logic [FCMWID-1:0] ld_msg;

  function automatic logic [FCMWID-1:0] flag_msg(input logic [FCMWID-1:0] m,
                                                 input logic [CNT_W-1:0]  k);
    logic [FCMWID-1:0] r;
    r = m;
    r[SOC_MSB:SOC_LSB] = (k == '0);
    r[EOC_MSB:EOC_LSB] = (k == LAST);
    return r;
  endfunction

  assign last = (state == SEND) && (idx == LAST);

`ifdef CPKT_SEG_BUF_EN
  logic              buf_full;
  logic [PW-1:0]     buf_dat;
  logic [FCMWID-1:0] buf_msg;
  logic              slot, to_buf;

  // A packet slot opens when idle or on the last cell; the buffer always has priority.
  assign cpkt_rdy = ~buf_full;
  assign accept   = cpkt_vld & cpkt_rdy;
  assign slot     = (state == IDLE) | last;
  assign load     = slot & (buf_full | accept);
  assign to_buf   = accept & ~(slot & ~buf_full);
  assign ld_dat   = buf_full ? buf_dat : cpkt_dat;
  assign ld_msg   = buf_full ? buf_msg : cpkt_msg;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_dat  <= '0;
      buf_msg  <= '0;
    end else if (to_buf) begin
      buf_full <= 1'b1;
      buf_dat  <= cpkt_dat;
      buf_msg  <= cpkt_msg;
    end else if (slot) begin
      buf_full <= 1'b0;
    end
  end
`else
  assign cpkt_rdy = (state == IDLE) | last;
  assign accept   = cpkt_vld & cpkt_rdy;
  assign load     = accept;
  assign ld_dat   = cpkt_dat;
  assign ld_msg   = cpkt_msg;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (load) begin
      state_nxt = SEND;
      idx_nxt   = '0;
    end else if (state == SEND && !last) begin
      idx_nxt = idx + 1'b1;
    end else begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Remaining cells live in a left-shifting register so the next cell is always the top slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_vld <= 1'b0;
      cell_dat <= '0;
      cell_msg <= '0;
      sh_q     <= '0;
      msg_q    <= '0;
    end else if (load) begin
      cell_vld <= 1'b1;
      cell_dat <= ld_dat[PW-1 -: DWID];
      cell_msg <= flag_msg(ld_msg, '0);
      sh_q     <= ld_dat << DWID;
      msg_q    <= ld_msg;
    end else if (state == SEND && !last) begin
      cell_vld <= 1'b1;
      cell_dat <= sh_q[PW-1 -: DWID];
      cell_msg <= flag_msg(msg_q, idx + 1'b1);
      sh_q     <= sh_q << DWID;
    end else begin
      cell_vld <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpkt_seg.sv
// Scoreboard bench for cpkt_seg: driver schedules expected cells per accepted packet,
// a negedge monitor checks every cycle's cell outputs and cpkt_rdy.
module tb_cpkt_seg;
  localparam int DW = 32;
  localparam int MW = 50;
  localparam int CS = 8;
  localparam int PW = DW * CS;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpkt_vld;
  logic [PW-1:0] cpkt_dat;
  logic [MW-1:0] cpkt_msg;
  logic          cpkt_rdy;
  logic          cell_vld;
  logic [DW-1:0] cell_dat;
  logic [MW-1:0] cell_msg;

  cpkt_seg #(.DWID(DW), .FCMWID(MW), .CELL_SZ(CS)) dut (
    .clk(clk), .rst(rst), .cpkt_vld(cpkt_vld), .cpkt_dat(cpkt_dat),
    .cpkt_msg(cpkt_msg), .cpkt_rdy(cpkt_rdy), .cell_vld(cell_vld),
    .cell_dat(cell_dat), .cell_msg(cell_msg)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
    logic [MW-1:0] msg;
  } cell_t;

  cell_t q[$];
  int    cyc = 0, next_free = 0, last_start = -1;
  int    n_chk = 0, n_fail = 0;
  bit    model_rdy = 1'b1, check_en = 1'b0, acc = 1'b0, rst_d = 1'b0;
  logic [DW-1:0] last_dat = '0;
  logic [MW-1:0] last_msg = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pkt();
    logic [PW-1:0] r;
    for (int i = 0; i < PW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_msg();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[MW-1:0];
  endfunction

  // One cycle of stimulus; the model decides acceptance from its own notion of readiness.
  task automatic drive(input bit v, input logic [PW-1:0] d, input logic [MW-1:0] m, input bit r);
    int start;
    logic [MW-1:0] em;
    @(posedge clk); #1;
    cyc++;
    rst = r; cpkt_vld = v; cpkt_dat = d; cpkt_msg = m;
`ifdef CPKT_SEG_BUF_EN
    model_rdy = (last_start <= cyc);
`else
    model_rdy = (next_free <= cyc + 1);
`endif
    check_en = 1'b1;
    acc = !r && v && model_rdy;
    if (acc) begin
      start = (cyc + 1 > next_free) ? cyc + 1 : next_free;
      for (int k = 0; k < CS; k++) begin
        em = m;
        em[3] = (k == 0);
        em[2] = (k == CS - 1);
        q.push_back('{start + k, d[DW*(CS-1-k) +: DW], em});
      end
      next_free  = start + CS;
      last_start = start;
    end
    if (r) begin
      while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
      next_free  = 0;
      last_start = -1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      bit    ev;
      cell_t e;
      if (rst_d) begin
        last_dat = '0;
        last_msg = '0;
      end
      ev = q.size() > 0 && q[0].cyc == cyc;
      chk("cell_vld", 64'(cell_vld), 64'(ev));
      if (ev) begin
        e = q.pop_front();
        last_dat = e.dat;
        last_msg = e.msg;
      end
      chk("cell_dat", 64'(cell_dat), 64'(last_dat));
      chk("cell_msg", 64'(cell_msg), 64'(last_msg));
      chk("cpkt_rdy", 64'(cpkt_rdy), 64'(model_rdy));
    end
    rst_d = rst;
  end

  initial begin
    logic [PW-1:0] d;
    logic [MW-1:0] m;
    int            w;
    rst = 1'b1; cpkt_vld = 1'b0; cpkt_dat = '0; cpkt_msg = '0;
    repeat (3) @(posedge clk);

    // Counting cells 0..7, zero msg
    for (int k = 0; k < CS; k++) d[DW*(CS-1-k) +: DW] = DW'(k);
    idle(2);
    drive(1'b1, d, '0, 1'b0);
    idle(10);

    // Non-flag msg bits must pass through
    m = '1; m[3:2] = 2'b00;
    drive(1'b1, rnd_pkt(), m, 1'b0);
    idle(10);

    // Back-to-back with cpkt_vld held high
    drive(1'b1, rnd_pkt(), rnd_msg(), 1'b0);
    d = rnd_pkt(); m = rnd_msg();
    w = 0;
    do begin
      drive(1'b1, d, m, 1'b0);
      w++;
    end while (!acc && w < 20);
    chk("b2b_accept", 64'(acc), 64'(1));
    idle(20);

    // Random traffic, data changing every cycle
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, rnd_pkt(), rnd_msg(), 1'b0);
    idle(20);

    // Reset while cell 3 is on the output, then a fresh packet
    drive(1'b1, rnd_pkt(), rnd_msg(), 1'b0);
    idle(3);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, 1'b1);
    drive(1'b1, rnd_pkt(), rnd_msg(), 1'b0);
    idle(12);

    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 1) != 0, rnd_pkt(), rnd_msg(), 1'b0);
    idle(25);
    chk("queue_drained", 64'(q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
